// File: rtl/reg_pipe_pkg.sv
// Shared defaults and helpers for the reg_pipe valid/data pipeline.
package reg_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 3;

    // Bits needed to represent a stage count in the range 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: a valid bit plus a data word.
// Define RESET_DATA_EN to make the data word resettable to RST_VAL.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_d,
    input  logic [WIDTH-1:0] data_d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (en) begin
            valid_reg <= valid_d;
        end
    end

    // Flush only kills the qualifier; data keeps following the enable.
`ifdef RESET_DATA_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= RST_VAL;
        end else if (en) begin
            data_reg <= data_d;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (en) begin
            data_reg <= data_d;
        end
    end

    logic unused_rst_val;
    assign unused_rst_val = ^RST_VAL;
`endif

    assign valid_q = valid_reg;
    assign data_q  = data_reg;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage enabled register pipeline with valid tracking, flush and occupancy count.
// Define RESET_DATA_EN to reset the data registers to RST_VAL as well.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter int               DEPTH   = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  logic [WIDTH-1:0]             d_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             q_o,
    output logic [cnt_width(DEPTH)-1:0]  count_o
);

    localparam int CW = cnt_width(DEPTH);

    // Index 0 is the pipeline input, index DEPTH the last stage output.
    logic [DEPTH:0]   valid_chain;
    logic [WIDTH-1:0] data_chain [DEPTH+1];

    assign valid_chain[0] = valid_i;
    assign data_chain[0]  = d_i;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            reg_pipe_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .en      (en_i),
                .flush   (flush_i),
                .valid_d (valid_chain[gi]),
                .data_d  (data_chain[gi]),
                .valid_q (valid_chain[gi+1]),
                .data_q  (data_chain[gi+1])
            );
        end
    endgenerate

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Incremental update: one entry leaves the tail, one may enter the head.
    always_comb begin
        count_next = count_reg;
        if (flush_i) begin
            count_next = '0;
        end else if (en_i) begin
            count_next = count_reg - CW'(valid_chain[DEPTH]) + CW'(valid_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign valid_o = valid_chain[DEPTH];
    assign q_o     = data_chain[DEPTH];
    assign count_o = count_reg;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed self-checking bench for reg_pipe (WIDTH=8, DEPTH=3).
module tb_reg_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_i;
    logic       flush_i;
    logic       valid_i;
    logic [7:0] d_i;
    logic       valid_o;
    logic [7:0] q_o;
    logic [1:0] count_o;

    int n_checks = 0;
    int n_fails  = 0;

    reg_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) dut (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .d_i     (d_i),
        .valid_o (valid_o),
        .q_o     (q_o),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] c);
        chk({tag, ".valid_o"}, 32'(valid_o), 32'(v));
        chk({tag, ".count_o"}, 32'(count_o), 32'(c));
    endtask

    initial begin
        logic [2:0] hist;
        logic [1:0] exp_cnt;

        reset = 1'b1; en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; d_i = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_out("reset", 1'b0, 2'd0);
`ifdef RESET_DATA_EN
        chk("reset.q_o", 32'(q_o), 32'h00);
`endif
        $display("step reset: valid_o=%0b count_o=%0d", valid_o, count_o);

        // Fill with A1..A3, then drain
        en_i = 1'b1; valid_i = 1'b1;
        d_i = 8'hA1; tick(); chk_out("fill1", 1'b0, 2'd1);
        d_i = 8'hA2; tick(); chk_out("fill2", 1'b0, 2'd2);
        d_i = 8'hA3; tick(); chk_out("fill3", 1'b1, 2'd3);
        chk("fill3.q_o", 32'(q_o), 32'hA1);
        $display("step fill: q_o=%0h valid_o=%0b count_o=%0d", q_o, valid_o, count_o);
        valid_i = 1'b0;
        tick(); chk_out("drain1", 1'b1, 2'd2); chk("drain1.q_o", 32'(q_o), 32'hA2);
        tick(); chk_out("drain2", 1'b1, 2'd1); chk("drain2.q_o", 32'(q_o), 32'hA3);
        tick(); chk_out("drain3", 1'b0, 2'd0);
        $display("step drain: valid_o=%0b count_o=%0d", valid_o, count_o);

        // Two entries in, then stall for 4 cycles
        valid_i = 1'b1;
        d_i = 8'hB1; tick();
        d_i = 8'hB2; tick(); chk_out("preload", 1'b0, 2'd2);
        en_i = 1'b0; d_i = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("stall", 1'b0, 2'd2);
        end
        $display("step stall: valid_o=%0b count_o=%0d", valid_o, count_o);
        en_i = 1'b1; valid_i = 1'b0;
        tick(); chk_out("resume1", 1'b1, 2'd2); chk("resume1.q_o", 32'(q_o), 32'hB1);
        tick(); chk_out("resume2", 1'b1, 2'd1); chk("resume2.q_o", 32'(q_o), 32'hB2);
        tick(); chk_out("resume3", 1'b0, 2'd0);
        $display("step resume: valid_o=%0b count_o=%0d", valid_o, count_o);

        // Flush a full pipe while still feeding valid data
        valid_i = 1'b1;
        d_i = 8'hC1; tick();
        d_i = 8'hC2; tick();
        d_i = 8'hC3; tick(); chk_out("full", 1'b1, 2'd3);
        flush_i = 1'b1; d_i = 8'hC4; tick(); chk_out("flush", 1'b0, 2'd0);
        flush_i = 1'b0;
        d_i = 8'hD1; tick(); chk_out("post_flush1", 1'b0, 2'd1);
        d_i = 8'hD2; tick(); chk_out("post_flush2", 1'b0, 2'd2);
        d_i = 8'hD3; tick(); chk_out("post_flush3", 1'b1, 2'd3);
        chk("post_flush3.q_o", 32'(q_o), 32'hD1);
        $display("step flush: q_o=%0h valid_o=%0b count_o=%0d", q_o, valid_o, count_o);

        // Flush must win even with en_i low
        en_i = 1'b0; flush_i = 1'b1; tick(); chk_out("flush_noen", 1'b0, 2'd0);
        flush_i = 1'b0; en_i = 1'b1;
        $display("step flush_noen: valid_o=%0b count_o=%0d", valid_o, count_o);

        // Reset mid-stream with two entries in flight
        valid_i = 1'b1;
        d_i = 8'hE1; tick();
        d_i = 8'hE2; tick(); chk_out("pre_reset", 1'b0, 2'd2);
        reset = 1'b1; tick(); chk_out("mid_reset", 1'b0, 2'd0);
        reset = 1'b0; valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("post_reset_idle", 1'b0, 2'd0);
        end
        valid_i = 1'b1; d_i = 8'hF1; tick(); chk_out("restart1", 1'b0, 2'd1);
        valid_i = 1'b0; tick(); tick();
        chk_out("restart3", 1'b1, 2'd1); chk("restart3.q_o", 32'(q_o), 32'hF1);
        tick(); chk_out("restart_empty", 1'b0, 2'd0);
        $display("step reset_mid: valid_o=%0b count_o=%0d", valid_o, count_o);

        // Alternating valid: expected values from a 3-bit valid history
        hist = 3'b000;
        for (int i = 0; i < 8; i++) begin
            valid_i = ~i[0];
            d_i = 8'(8'h10 + i);
            tick();
            hist = {hist[1:0], valid_i};
            exp_cnt = 2'(hist[0]) + 2'(hist[1]) + 2'(hist[2]);
            chk_out("alt", hist[2], exp_cnt);
            if (hist[2]) chk("alt.q_o", 32'(q_o), 32'(8'(8'h10 + i - 2)));
            $display("step alt %0d: valid_o=%0b count_o=%0d q_o=%0h", i, valid_o, count_o, q_o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 SHALL have parameter RST_VAL, default all-zeros, WIDTH-bit data reset value.
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en_i  input  1  advance enable; 0 = all stages hold.
REQ-007 SHALL have port flush_i  input  1  clear all valid bits.
REQ-008 SHALL have port valid_i  input  1  qualifier for d_i.
REQ-009 SHALL have port d_i  input  WIDTH  data into stage 0.
REQ-010 SHALL have port valid_o  output  1  valid bit of last stage.
REQ-011 SHALL have port q_o  output  WIDTH  data of last stage.
REQ-012 SHALL have port count_o  output  $clog2(DEPTH+1)  number of stages holding valid data.

Function
REQ-013 SHALL hold DEPTH stages, each one valid bit plus WIDTH data bits, all registered on clk rising edge.
REQ-014 SHALL, when en_i=1 and flush_i=0, load stage 0 with {valid_i,d_i} and stage k with stage k-1, for k=1..DEPTH-1.
REQ-015 SHALL, when en_i=0 and flush_i=0, hold every stage and count_o unchanged.
REQ-016 SHALL shift data regardless of valid_i; valid travels alongside data.
REQ-017 SHALL have latency exactly DEPTH enabled cycles from d_i to q_o; stall cycles (en_i=0) add one cycle each.
REQ-018 SHALL drive valid_o/q_o directly from the last-stage registers, with no combinational path from inputs.
REQ-019 SHALL, on flush_i=1, clear all valid bits and count_o to 0 next edge, regardless of en_i and valid_i.
REQ-020 SHALL have flush_i not modify data registers; the data shift still follows en_i.
REQ-021 SHALL give priority reset > flush_i > en_i.
REQ-022 SHALL update count_o as count - last_valid + valid_i when advancing, saturating is never needed; range 0..DEPTH.
REQ-023 SHALL at all times keep count_o equal to the popcount of the stage valid bits.
REQ-024 SHALL for DEPTH=1 behave as a single enabled register with valid; count_o is 1 bit.

Reset
REQ-025 SHALL clear all valid bits, valid_o, and count_o on reset=1 at a clk edge.
REQ-026 SHALL have reset asserted mid-stream discard all in-flight data; first valid_o after release is DEPTH enabled cycles after the first accepted valid_i.
REQ-027 SHALL treat data register reset per REQ-028/029.

Configuration
REQ-028 SHALL, with RESET_DATA_EN defined, load RST_VAL into every data register on reset; q_o=RST_VAL after reset.
REQ-029 SHALL, without RESET_DATA_EN, have data registers non-resettable (q_o undefined until loaded); valid/count reset unchanged.

Structure
REQ-030 SHALL place default WIDTH/DEPTH constants and a count-width function in package reg_pipe_pkg.
REQ-031 SHALL instantiate sub-module reg_pipe_stage (one valid+data register with en, flush, reset) DEPTH times via generate.
REQ-032 SHALL implement the counter in reg_pipe, not in the stages.

Verification (WIDTH=8, DEPTH=3)
REQ-033 SHALL verify reset held 2 cycles, then released -> valid_o=0, count_o=0, q_o=8'h00 with RESET_DATA_EN.
REQ-034 SHALL verify en_i=1, valid_i=1, d_i=8'hA1,8'hA2,8'hA3 on consecutive cycles -> q_o=8'hA1 valid_o=1 on third edge after first input; count_o reaches 3.
REQ-035 SHALL verify that, after two inputs loaded, en_i=0 for 4 cycles -> stages, q_o, and count_o=2 hold; resuming en_i, 8'hA1 exits one cycle later.
REQ-036 SHALL verify that, with pipe full (count_o=3), flush_i=1 and en_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0; later entries flow normally.
REQ-037 SHALL verify that reset=1 asserted mid-stream with count_o=2 -> next edge count_o=0, valid_o=0; without RESET_DATA_EN, valid_o stays 0 until new data arrives.
REQ-038 SHALL verify alternating valid_i=1/0 with en_i=1 -> valid_o pattern is 1,0,1,... delayed 3 cycles; count_o toggles 1..2 and matches popcount every cycle.
